// File: rtl/stonyman_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : stonyman_pkg
//  Description : Shared constants, state encoding and dimension clamp for the
//                Stonyman row-assembly path.
//  Revision    : 1.0 - initial release
// ============================================================================
package stonyman_pkg;

    localparam int MAX_RESOLUTION = 112;
    localparam int PIXEL_WIDTH    = 8;
    localparam int ROW_W          = MAX_RESOLUTION * PIXEL_WIDTH;
    localparam int CNT_W          = 7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // A zero or oversized request means "use the full sensor width/height".
    function automatic logic [CNT_W-1:0] clamp_dim(
        input logic [CNT_W-1:0] req,
        input int unsigned      max_res
    );
        if ((req == '0) || (32'(req) > max_res)) begin
            return CNT_W'(max_res);
        end
        return req;
    endfunction

endpackage
`default_nettype wire

// File: rtl/line_shadow_buf.sv
`default_nettype none
// ============================================================================
//  Module      : line_shadow_buf
//  Description : Indexed-write pixel register file with synchronous clear;
//                the flat view already includes the write being applied.
//  Revision    : 1.0 - initial release
// ============================================================================
module line_shadow_buf #(
    parameter int DEPTH = 112,
    parameter int WIDTH = 8,
    parameter int IDX_W = 7
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   wr_en,
    input  logic [IDX_W-1:0]       wr_idx,
    input  logic [WIDTH-1:0]       wr_data,
    output logic [DEPTH*WIDTH-1:0] row_view
);

    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_slot
            logic [WIDTH-1:0] slot_q;
            logic [WIDTH-1:0] slot_d;
            logic             hit;

            always_comb begin
                hit    = wr_en && (wr_idx == IDX_W'(i));
                slot_d = slot_q;
                if (clear) begin
                    slot_d = '0;
                end else if (hit) begin
                    slot_d = wr_data;
                end
            end

            always_ff @(posedge clock) begin
                if (reset) begin
                    slot_q <= '0;
                end else begin
                    slot_q <= slot_d;
                end
            end

            // Bypass lets the top publish a row in the same cycle as its last pixel.
            assign row_view[i*WIDTH +: WIDTH] = hit ? wr_data : slot_q;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/stonyman_line_assembler.sv
`default_nettype none
// ============================================================================
//  Module      : stonyman_line_assembler
//  Description : Collects the serial ADC pixel stream into rows and publishes
//                each complete row as a stable wide bus with a strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
module stonyman_line_assembler #(
    parameter int MAX_RESOLUTION = stonyman_pkg::MAX_RESOLUTION,
    parameter int PIXEL_WIDTH    = stonyman_pkg::PIXEL_WIDTH
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                frame_start,
    input  logic [6:0]                          num_cols,
    input  logic [6:0]                          num_rows,
    input  logic [PIXEL_WIDTH-1:0]              pixel_data,
    input  logic                                pixel_valid,
    output logic [MAX_RESOLUTION*PIXEL_WIDTH-1:0] img_buf_newline,
    output logic                                newline_strobe,
    output logic [6:0]                          line_index,
    output logic                                frame_capture_done,
    output logic                                overflow_err
);
    import stonyman_pkg::*;

    localparam int ROW_BITS = MAX_RESOLUTION * PIXEL_WIDTH;

    state_e              state_q,      state_d;
    logic [CNT_W-1:0]    cols_q,       cols_d;
    logic [CNT_W-1:0]    rows_q,       rows_d;
    logic [CNT_W-1:0]    col_cnt_q,    col_cnt_d;
    logic [CNT_W-1:0]    row_cnt_q,    row_cnt_d;
    logic [ROW_BITS-1:0] row_q,        row_d;
    logic                strobe_q,     strobe_d;
    logic [CNT_W-1:0]    line_index_q, line_index_d;
    logic                done_q,       done_d;
    logic                overflow_q,   overflow_d;

    logic                buf_clear;
    logic                buf_wr;
    logic [ROW_BITS-1:0] buf_view;

    line_shadow_buf #(
        .DEPTH (MAX_RESOLUTION),
        .WIDTH (PIXEL_WIDTH),
        .IDX_W (CNT_W)
    ) u_shadow (
        .clock    (clock),
        .reset    (reset),
        .clear    (buf_clear),
        .wr_en    (buf_wr),
        .wr_idx   (col_cnt_q),
        .wr_data  (pixel_data),
        .row_view (buf_view)
    );

    always_comb begin
        state_d      = state_q;
        cols_d       = cols_q;
        rows_d       = rows_q;
        col_cnt_d    = col_cnt_q;
        row_cnt_d    = row_cnt_q;
        row_d        = row_q;
        strobe_d     = 1'b0;
        line_index_d = line_index_q;
        done_d       = done_q;
        overflow_d   = overflow_q;
        buf_clear    = 1'b0;
        buf_wr       = 1'b0;

        // A new frame always wins, even over a same-cycle pixel.
        if (frame_start) begin
            state_d   = ST_FILL;
            cols_d    = clamp_dim(num_cols, MAX_RESOLUTION);
            rows_d    = clamp_dim(num_rows, MAX_RESOLUTION);
            col_cnt_d = '0;
            row_cnt_d = '0;
            done_d    = 1'b0;
            buf_clear = 1'b1;
        end else if (pixel_valid) begin
            case (state_q)
                ST_FILL: begin
                    buf_wr = 1'b1;
                    if (col_cnt_q == (cols_q - CNT_W'(1))) begin
                        row_d        = buf_view;
                        strobe_d     = 1'b1;
                        line_index_d = row_cnt_q;
                        col_cnt_d    = '0;
                        buf_clear    = 1'b1;
                        if (row_cnt_q == (rows_q - CNT_W'(1))) begin
                            state_d   = ST_DONE;
                            done_d    = 1'b1;
                            row_cnt_d = '0;
                        end else begin
                            row_cnt_d = row_cnt_q + CNT_W'(1);
                        end
                    end else begin
                        col_cnt_d = col_cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    overflow_d = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cols_q       <= CNT_W'(MAX_RESOLUTION);
            rows_q       <= CNT_W'(MAX_RESOLUTION);
            col_cnt_q    <= '0;
            row_cnt_q    <= '0;
            row_q        <= '0;
            strobe_q     <= 1'b0;
            line_index_q <= '0;
            done_q       <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cols_q       <= cols_d;
            rows_q       <= rows_d;
            col_cnt_q    <= col_cnt_d;
            row_cnt_q    <= row_cnt_d;
            row_q        <= row_d;
            strobe_q     <= strobe_d;
            line_index_q <= line_index_d;
            done_q       <= done_d;
            overflow_q   <= overflow_d;
        end
    end

    assign img_buf_newline    = row_q;
    assign newline_strobe     = strobe_q;
    assign line_index         = line_index_q;
    assign frame_capture_done = done_q;
    assign overflow_err       = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_stonyman_line_assembler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stonyman_line_assembler
//  Description : Scoreboard bench for the row assembler with a queue-based
//                reference model of frames, rows and error flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_stonyman_line_assembler;

    localparam int MAXR = 112;
    localparam int RW   = MAXR * 8;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          frame_start = 1'b0;
    logic [6:0]    num_cols = '0;
    logic [6:0]    num_rows = '0;
    logic [7:0]    pixel_data = '0;
    logic          pixel_valid = 1'b0;
    logic [RW-1:0] img_buf_newline;
    logic          newline_strobe;
    logic [6:0]    line_index;
    logic          frame_capture_done;
    logic          overflow_err;

    stonyman_line_assembler dut (
        .clock              (clock),
        .reset              (reset),
        .frame_start        (frame_start),
        .num_cols           (num_cols),
        .num_rows           (num_rows),
        .pixel_data         (pixel_data),
        .pixel_valid        (pixel_valid),
        .img_buf_newline    (img_buf_newline),
        .newline_strobe     (newline_strobe),
        .line_index         (line_index),
        .frame_capture_done (frame_capture_done),
        .overflow_err       (overflow_err)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [RW-1:0] row;
        logic [6:0]    li;
        bit            last;
        int            cyc;
    } exp_t;

    exp_t expq[$];
    exp_t e;

    // Reference model state
    int         m_cols = MAXR;
    int         m_rows = MAXR;
    int         m_row  = 0;
    logic [7:0] m_pix[$];
    bit         m_active = 0;
    bit         m_done   = 0;
    bit         m_ovf    = 0;
    bit         vis_done = 0;
    bit         vis_ovf  = 0;
    logic [RW-1:0] last_row = '0;
    logic [6:0]    last_li  = '0;

    always @(posedge clock) begin
        vis_done <= m_done;
        vis_ovf  <= m_ovf;
    end

    task automatic check(input string name, input bit ok, input string detail);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: %s", name, detail);
        end
    endtask

    function automatic int clampd(input int n);
        return ((n == 0) || (n > MAXR)) ? MAXR : n;
    endfunction

    // Drive one cycle of inputs and advance the model to what the next edge must do.
    task automatic step(input bit fs, input int nc, input int nr, input bit pv, input logic [7:0] pd);
        logic [RW-1:0] r;
        exp_t x;
        frame_start = fs;
        num_cols    = nc[6:0];
        num_rows    = nr[6:0];
        pixel_valid = pv;
        pixel_data  = pd;
        if (fs) begin
            m_cols   = clampd(int'(nc[6:0]));
            m_rows   = clampd(int'(nr[6:0]));
            m_row    = 0;
            m_pix.delete();
            m_active = 1;
            m_done   = 0;
        end else if (pv) begin
            if (!m_active) begin
                m_ovf = 1;
            end else begin
                m_pix.push_back(pd);
                if (m_pix.size() == m_cols) begin
                    r = '0;
                    for (int k = 0; k < m_pix.size(); k++) r[k*8 +: 8] = m_pix[k];
                    x.row  = r;
                    x.li   = 7'(m_row);
                    x.last = (m_row == m_rows - 1);
                    x.cyc  = cyc + 1;
                    expq.push_back(x);
                    m_pix.delete();
                    if (x.last) begin
                        m_active = 0;
                        m_done   = 1;
                    end else begin
                        m_row++;
                    end
                end
            end
        end
        @(posedge clock);
        #1;
        frame_start = 1'b0;
        pixel_valid = 1'b0;
    endtask

    task automatic start_frame(input int nc, input int nr);
        step(1, nc, nr, 0, 8'h00);
    endtask

    task automatic pix(input logic [7:0] d);
        step(0, int'($urandom_range(0, 127)), int'($urandom_range(0, 127)), 1, d);
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0, 0, 0, 8'h00);
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        frame_start = 1'b0;
        pixel_valid = 1'b0;
        m_active = 0;
        m_done   = 0;
        m_ovf    = 0;
        m_pix.delete();
        expq.delete();
        last_row = '0;
        last_li  = '0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    // Monitor: consumes expected rows when the DUT strobes, and checks flags every cycle.
    always @(negedge clock) begin
        if (newline_strobe) begin
            if (expq.size() == 0) begin
                check("unexpected_strobe", 0, $sformatf("got strobe line_index=%0d, want no strobe", line_index));
            end else begin
                e = expq.pop_front();
                check("strobe_cycle", cyc == e.cyc, $sformatf("got cycle %0d want %0d", cyc, e.cyc));
                check("row_data", img_buf_newline === e.row,
                      $sformatf("got %h want %h", img_buf_newline, e.row));
                check("line_index", line_index === e.li, $sformatf("got %0d want %0d", line_index, e.li));
                check("done_on_strobe", frame_capture_done === e.last,
                      $sformatf("got %0b want %0b", frame_capture_done, e.last));
                last_row = e.row;
                last_li  = e.li;
            end
        end else begin
            if ((expq.size() > 0) && (expq[0].cyc < cyc)) begin
                check("missing_strobe", 0, $sformatf("got no strobe by cycle %0d want strobe at %0d", cyc, expq[0].cyc));
                void'(expq.pop_front());
            end
            if (!reset) begin
                check("row_stable", img_buf_newline === last_row,
                      $sformatf("got %h want %h", img_buf_newline, last_row));
                check("index_stable", line_index === last_li, $sformatf("got %0d want %0d", line_index, last_li));
            end
        end
        check("done_flag", frame_capture_done === vis_done,
              $sformatf("got %0b want %0b at cycle %0d", frame_capture_done, vis_done, cyc));
        check("overflow_flag", overflow_err === vis_ovf,
              $sformatf("got %0b want %0b at cycle %0d", overflow_err, vis_ovf, cyc));
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        @(posedge clock);
        #1;
        do_reset();
        idle(2);

        // Single full-width row, value = index
        start_frame(112, 1);
        for (int k = 0; k < 112; k++) pix(8'(k));
        idle(3);

        // Narrow rows, all ones
        start_frame(50, 3);
        repeat (150) pix(8'hFF);
        idle(3);

        // Gapped input
        start_frame(4, 2);
        for (int k = 0; k < 8; k++) begin
            pix(8'($urandom));
            idle(1);
        end
        idle(2);

        // Abort mid-row
        start_frame(112, 2);
        repeat (30) pix(8'($urandom));
        start_frame(112, 1);
        repeat (112) pix(8'($urandom));
        idle(2);

        // Back-to-back single-pixel rows
        start_frame(1, 5);
        repeat (5) pix(8'($urandom));
        idle(2);

        // Clamp with frame_start/pixel_valid collision
        step(1, 0, 1, 1, 8'hAA);
        for (int k = 0; k < 111; k++) pix(8'(k + 1));
        idle(2);
        pix(8'h5A);
        idle(2);
        check("collision_no_overflow", overflow_err === 1'b0, $sformatf("got %0b want 0", overflow_err));

        // Row count clamp and oversize column clamp
        start_frame(2, 0);
        repeat (224) pix(8'($urandom));
        idle(2);
        start_frame(127, 1);
        repeat (112) pix(8'($urandom));
        idle(2);

        // Overflow: pixel in IDLE after reset, sticky across a frame, cleared by reset
        do_reset();
        pix(8'h11);
        idle(2);
        check("overflow_set", overflow_err === 1'b1, $sformatf("got %0b want 1", overflow_err));
        start_frame(3, 1);
        repeat (3) pix(8'($urandom));
        idle(2);
        check("overflow_sticky", overflow_err === 1'b1, $sformatf("got %0b want 1", overflow_err));
        do_reset();
        idle(1);
        check("overflow_cleared", overflow_err === 1'b0, $sformatf("got %0b want 0", overflow_err));

        // Randomized frames with gaps, aborts and stray pixels
        for (int f = 0; f < 20; f++) begin
            start_frame(int'($urandom_range(0, 127)), int'($urandom_range(1, 4)));
            n = 0;
            while (m_active && (n < 3000)) begin
                if ($urandom_range(0, 399) == 0)
                    step(1, int'($urandom_range(0, 127)), int'($urandom_range(1, 3)),
                         $urandom_range(0, 1) == 1, 8'($urandom));
                else
                    step(0, int'($urandom_range(0, 127)), int'($urandom_range(0, 127)),
                         $urandom_range(0, 3) != 0, 8'($urandom));
                n++;
            end
            for (int k = 0; k < 4; k++) begin
                if ($urandom_range(0, 5) == 0) pix(8'($urandom));
                else idle(1);
            end
        end

        idle(5);
        check("queue_drained", expq.size() == 0, $sformatf("got %0d pending rows want 0", expq.size()));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
